// File: rtl/break_controller_pkg.sv
// Shared constants for the run/halt/step controller and the break countdown.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package break_controller_pkg;

    // Controller state encodings.
    typedef enum logic [1:0] {
        BRK_RUN    = 2'd0,
        BRK_HALTED = 2'd1,
        BRK_STEP   = 2'd2
    } brk_state_t;

    // Resume long-press length used by the countdown instance in the clock
    // subsystem; the controller only sees its timed_up pulse.
    localparam int unsigned TIMEUP_CYCLES = 8;

    // Width of the per-step burst counter (STEP_CYCLES is limited to 1..255).
    localparam int unsigned BURST_WIDTH = 8;

endpackage

// File: rtl/break_controller.sv
// Run/halt/single-step controller gating the core clock enable.
// Latency: break -> enable low next cycle; step edge -> STEP_CYCLES enable cycles starting next cycle.
// Backpressure: none; events outside their accepting state are dropped, not queued.
//
// Ports:
//   clock_50mhz        system clock; reset is synchronous, active-high
//   break_request      one-cycle halt request (ebreak or break button)
//   resume_button      debounced level; held through the countdown to resume
//   step_button        debounced level; rising edge in HALTED issues a burst
//   countdown_timed_up one-cycle pulse from the external countdown
//   countdown_enable   runs the external countdown; low clears it
//   core_clock_enable  qualifies core clock edges
//   halted             high in HALTED and STEP
//   step_count         steps issued since the last halt entry (saturating)
module break_controller
    import break_controller_pkg::*;
#(
    parameter int unsigned STEP_CYCLES      = 1,
    parameter int unsigned STEP_COUNT_WIDTH = 16,
    parameter int unsigned START_HALTED     = 0
) (
    input  logic                        clock_50mhz,
    input  logic                        reset,
    input  logic                        break_request,
    input  logic                        resume_button,
    input  logic                        step_button,
    input  logic                        countdown_timed_up,
    output logic                        countdown_enable,
    output logic                        core_clock_enable,
    output logic                        halted,
    output logic [STEP_COUNT_WIDTH-1:0] step_count
);

    localparam brk_state_t RESET_STATE  = (START_HALTED != 0) ? BRK_HALTED : BRK_RUN;
    localparam logic       RESET_CCE    = (START_HALTED == 0);
    localparam logic       RESET_HALTED = (START_HALTED != 0);

    brk_state_t                  r_state;
    logic                        r_core_clock_enable;
    logic                        r_halted;
    logic [STEP_COUNT_WIDTH-1:0] r_step_count;
    logic [BURST_WIDTH-1:0]      r_burst;
    logic                        r_step_prev;

    logic w_step_edge;
    logic w_resume;

    assign w_step_edge = step_button & ~r_step_prev;
    // Timeout only counts while the button is still held.
    assign w_resume    = countdown_timed_up & resume_button;

    // Combinational so a release drops the countdown in the same cycle.
    assign countdown_enable  = (r_state == BRK_HALTED) & resume_button;
    assign core_clock_enable = r_core_clock_enable;
    assign halted            = r_halted;
    assign step_count        = r_step_count;

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            r_state             <= RESET_STATE;
            r_core_clock_enable <= RESET_CCE;
            r_halted            <= RESET_HALTED;
            r_step_count        <= '0;
            r_burst             <= '0;
            r_step_prev         <= 1'b0;
        end else begin
            // Sampled in every state so a button held across a halt entry
            // does not produce a step.
            r_step_prev <= step_button;

            case (r_state)
                BRK_RUN: begin
                    if (break_request) begin
                        r_state             <= BRK_HALTED;
                        r_core_clock_enable <= 1'b0;
                        r_halted            <= 1'b1;
                        r_step_count        <= '0;
                    end
                end

                BRK_HALTED: begin
                    // Resume has priority over a coincident step edge.
                    if (w_resume) begin
                        r_state             <= BRK_RUN;
                        r_core_clock_enable <= 1'b1;
                        r_halted            <= 1'b0;
                    end else if (w_step_edge) begin
                        r_state             <= BRK_STEP;
                        r_core_clock_enable <= 1'b1;
                        r_burst             <= BURST_WIDTH'(STEP_CYCLES);
                        if (r_step_count != '1) begin
                            r_step_count <= r_step_count + STEP_COUNT_WIDTH'(1);
                        end
                    end
                end

                BRK_STEP: begin
                    // Leaving on the count of 1 yields exactly STEP_CYCLES
                    // enabled cycles; <= also guards a zero load.
                    if (r_burst <= BURST_WIDTH'(1)) begin
                        r_state             <= BRK_HALTED;
                        r_core_clock_enable <= 1'b0;
                        r_burst             <= '0;
                    end else begin
                        r_burst <= r_burst - BURST_WIDTH'(1);
                    end
                end

                default: begin
                    r_state             <= BRK_RUN;
                    r_core_clock_enable <= 1'b1;
                    r_halted            <= 1'b0;
                end
            endcase
        end
    end

endmodule
